mem_fill_ctrl: RTL and testbench
================================

# mem_fill_ctrl

Shared miss handler between the instruction and data caches and the multi-cycle main memory. It arbitrates I-cache misses, D-cache misses and D-cache write-through stores onto the single memory port. On a miss it streams an 8-word (16-byte) block back into the requesting cache's data array, then updates that cache's tag. It sits directly below the IF-stage I-cache and MEM-stage D-cache and drives their fill/stall handshakes.

## Interface
- MEM_LATENCY, 4, cycles from a memory read request to its `mem_data_valid` response
- WORDS_PER_BLOCK, 8, words per cache block; fixed at 8 in this design
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_miss, d_miss  in  1  miss requests; level signals, held by the cache until its `*_fill_done`
- i_miss_addr, d_miss_addr  in  16  byte address of the missing access
- d_store  in  1  write-through store request; level signal, held until `d_store_done`
- d_store_addr, d_store_data  in  16  store address and data
- mem_en, mem_wr  out  1  memory request valid; write select
- mem_addr, mem_wdata  out  16  memory address and write data
- mem_data_valid  in  1  read data valid
- mem_rdata  in  16  read data
- fill_data  out  16  registered copy of `mem_rdata`, driven to both caches
- fill_word  out  3  word index within the block for `fill_data`
- i_fill_we, d_fill_we  out  1  data-array write enables
- i_tag_we, d_tag_we  out  1  tag and valid write enables
- i_fill_done, d_fill_done, d_store_done  out  1  single-cycle completion pulses
- busy  out  1  high in every state other than IDLE

## Operation
- States: IDLE, FILL, DONE.
- IDLE arbitration uses fixed priority: d_miss, then d_store, then i_miss.
- Store in IDLE:
  - One cycle with mem_en=1, mem_wr=1, mem_addr=d_store_addr, mem_wdata=d_store_data.
  - d_store_done pulses in that same cycle.
  - State stays IDLE; the store can be re-arbitrated in the following cycle.
- Miss accepted in IDLE:
  - Latch the owner (I or D) and base = miss_addr & 16'hFFF0.
  - Move to FILL.
- FILL issue side:
  - Issue counter k runs 0..7.
  - Each cycle: mem_en=1, mem_wr=0, mem_addr = base | (k<<1).
  - No issue once k reaches 8.
- FILL receive side:
  - Each mem_data_valid registers the data and presents it the next cycle as fill_data, fill_word=r, owner *_fill_we=1.
  - Receive counter r then increments.
  - After the 8th word is presented, move to DONE.
- DONE lasts one cycle: owner *_tag_we=1 and *_fill_done=1, then return to IDLE.
- The owner's miss line dropping mid-fill is ignored; the fill completes.
- mem_data_valid is ignored in IDLE and DONE, and whenever r has reached 8. This covers stale responses after a reset.
- The non-owner's miss or store waits in IDLE until the fill completes. There is no preemption.
- Counters are 4 bits wide, saturating at 8; fill_word = r[2:0].

## Timing
- Reset: all outputs 0, state IDLE, counters 0, owner = D.
- Miss sampled in IDLE cycle N:
  - Requests issue in cycles N+1..N+8.
  - Data valid in N+1+MEM_LATENCY .. N+8+MEM_LATENCY.
  - Fill writes one cycle after each data-valid.
  - DONE in cycle N+10+MEM_LATENCY (N+14 with default), back in IDLE at N+15.
- Store latency: 1 cycle; done in the acceptance cycle.
- All outputs are registered, except mem_* and d_store_done in the store cycle, which are decoded from state and inputs.
- busy is high from N+1 through the DONE cycle.

## Structure
- Shared package `cache_pkg` holds:
  - state enum
  - BLOCK_BYTES = 16
  - WORD_IDX_W = 3
  - OFFSET_MASK = 16'hFFF0
  - owner encoding
- Sub-module `fill_counter`: 4-bit saturating counter with clear and increment. It is instantiated twice, once for issue and once for receive.

## Test plan
- D miss, addr 0x1236, memory returns 0xA000+k per word:
  - mem_addr sequence is 0x1230..0x123E.
  - d_fill_we in N+6..N+13 with fill_word 0..7.
  - d_tag_we and d_fill_done in N+14.
- i_miss and d_miss asserted in the same cycle:
  - D fill completes first.
  - I requests start the cycle after IDLE is re-entered (N+16).
- d_store at 0x0040 with data 0xBEEF while idle:
  - mem_wr=1, mem_addr=0x0040, d_store_done in the same cycle.
  - busy stays 0.
- Miss at addr 0xFFFE: addresses 0xFFF0..0xFFFE with no wrap; I owner writes only the i_* enables.
- rst_n low at N+5 of a fill, with data still returning:
  - All outputs 0 next cycle.
  - Stale mem_data_valid produces no *_fill_we.
  - A new miss is accepted normally afterwards.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss/fill path: FSM states, owner encoding,
// block geometry and address masking.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillState_e;

    typedef enum logic {
        OWNER_D = 1'b0,
        OWNER_I = 1'b1
    } owner_e;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned WORD_IDX_W  = 3;
    localparam int unsigned CNT_W       = 4;
    localparam logic [15:0] OFFSET_MASK = 16'hFFF0;

    function automatic logic [15:0] blockBase(input logic [15:0] addr);
        return addr & OFFSET_MASK;
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Saturating word counter for the fill engine; clear has priority over increment.
module fill_counter
    import cache_pkg::*;
#(
    parameter int unsigned MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(MAX))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_fill_ctrl.sv
// Shared I/D-cache miss handler: arbitrates misses and write-through stores onto
// one memory port and streams 8-word blocks back into the owning cache.
module mem_fill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned MEM_LATENCY     = 4,
    parameter int unsigned WORDS_PER_BLOCK = BLOCK_BYTES / 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_store,
    input  logic [15:0] d_store_addr,
    input  logic [15:0] d_store_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic        i_tag_we,
    output logic        d_tag_we,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        d_store_done,
    output logic        busy
);

    // Only the 8-word block with a non-zero memory latency is supported.
    if (MEM_LATENCY == 0 || WORDS_PER_BLOCK != 8) begin : gUnsupportedConfig
    end

    fillState_e             state, nextState;
    owner_e                 owner;
    logic [15:0]            base;
    logic [15:0]            fillDataQ;
    logic [WORD_IDX_W-1:0]  fillWordQ;
    logic                   fillWeQ;
    logic [CNT_W-1:0]       issueCnt, recvCnt;
    logic                   issueFull, recvFull;
    logic                   storeGo, acceptMiss, recvGo, inFill;

    assign inFill     = (state == FILL);
    assign issueFull  = issueCnt[CNT_W-1];
    assign recvFull   = recvCnt[CNT_W-1];
    // d_miss outranks the store, which outranks i_miss.
    assign storeGo    = (state == IDLE) && !d_miss && d_store;
    assign acceptMiss = (state == IDLE) && (d_miss || (!d_store && i_miss));
    assign recvGo     = inFill && mem_data_valid && !recvFull;

    fill_counter #(.MAX(WORDS_PER_BLOCK)) uIssueCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!inFill),
        .inc   (inFill),
        .count (issueCnt)
    );

    fill_counter #(.MAX(WORDS_PER_BLOCK)) uRecvCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!inFill),
        .inc   (recvGo),
        .count (recvCnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (acceptMiss) nextState = FILL;
            FILL:    if (recvFull)   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner     <= OWNER_D;
            base      <= '0;
            fillDataQ <= '0;
            fillWordQ <= '0;
            fillWeQ   <= 1'b0;
        end else begin
            if (acceptMiss) begin
                owner <= d_miss ? OWNER_D : OWNER_I;
                base  <= blockBase(d_miss ? d_miss_addr : i_miss_addr);
            end
            fillWeQ <= recvGo;
            if (recvGo) begin
                fillDataQ <= mem_rdata;
                fillWordQ <= recvCnt[WORD_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        d_store_done = 1'b0;
        i_tag_we     = 1'b0;
        d_tag_we     = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        fill_data    = fillDataQ;
        fill_word    = fillWordQ;
        i_fill_we    = fillWeQ && (owner == OWNER_I);
        d_fill_we    = fillWeQ && (owner == OWNER_D);
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (storeGo) begin
                    mem_en       = 1'b1;
                    mem_wr       = 1'b1;
                    mem_addr     = d_store_addr;
                    mem_wdata    = d_store_data;
                    d_store_done = 1'b1;
                end
            end
            FILL: begin
                if (!issueFull) begin
                    mem_en   = 1'b1;
                    mem_addr = base | {11'b0, issueCnt, 1'b0};
                end
            end
            DONE: begin
                i_tag_we    = (owner == OWNER_I);
                d_tag_we    = (owner == OWNER_D);
                i_fill_done = (owner == OWNER_I);
                d_fill_done = (owner == OWNER_D);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Scoreboard bench for mem_fill_ctrl: stimulus queues expected memory requests,
// fill writes and completions; negedge monitors pop and compare.
module tb_mem_fill_ctrl;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_store = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_store_addr = '0, d_store_data = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we;
    logic        i_fill_done, d_fill_done, d_store_done, busy;

    mem_fill_ctrl #(.MEM_LATENCY(LAT), .WORDS_PER_BLOCK(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .d_store        (d_store),
        .d_store_addr   (d_store_addr),
        .d_store_data   (d_store_data),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_data_valid (mem_data_valid),
        .mem_rdata      (mem_rdata),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .i_fill_we      (i_fill_we),
        .d_fill_we      (d_fill_we),
        .i_tag_we       (i_tag_we),
        .d_tag_we       (d_tag_we),
        .i_fill_done    (i_fill_done),
        .d_fill_done    (d_fill_done),
        .d_store_done   (d_store_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        busy;
    } memEnt_t;

    typedef struct packed {
        int unsigned cyc;
        logic        isI;
        logic [2:0]  word;
        logic [15:0] data;
    } fillEnt_t;

    typedef struct packed {
        int unsigned cyc;
        logic        isI;
    } doneEnt_t;

    typedef struct packed {
        int unsigned due;
        logic [15:0] data;
    } resp_t;

    memEnt_t  memExp[$];
    fillEnt_t fillExp[$];
    doneEnt_t doneExp[$];
    resp_t    respQ[$];

    int unsigned cyc = 0;
    int          nCompared = 0;
    int          nMismatch = 0;
    logic        monEn = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        nCompared++;
        nMismatch++;
        $display("FAIL %s: unexpected output at cycle %0d", name, cyc);
    endtask

    function automatic logic [15:0] memWord(input logic [15:0] a);
        logic [15:0] k;
        k = {13'b0, a[3:1]};
        return (a[15:4] == 12'h123) ? (16'hA000 + k) : ~a;
    endfunction

    // Memory: a read issued in cycle c returns valid data in cycle c+LAT.
    always @(negedge clk) begin
        if (respQ.size() > 0 && respQ[0].due == cyc) begin
            mem_data_valid = 1'b1;
            mem_rdata      = respQ[0].data;
            void'(respQ.pop_front());
        end else begin
            mem_data_valid = 1'b0;
            mem_rdata      = 16'h0;
        end
        if (mem_en === 1'b1 && mem_wr === 1'b0)
            respQ.push_back('{due: cyc + LAT, data: memWord(mem_addr)});
    end

    always @(negedge clk) begin : monitor
        memEnt_t  me;
        fillEnt_t fe;
        doneEnt_t de;
        if (monEn) begin
            if (mem_en === 1'b1) begin
                if (memExp.size() == 0) flag("mem_en");
                else begin
                    me = memExp.pop_front();
                    chk("mem_cycle", 64'(cyc), 64'(me.cyc));
                    chk("mem_req", {mem_wr, mem_addr, mem_wdata, d_store_done, busy},
                        {me.wr, me.addr, me.wdata, me.wr, me.busy});
                end
            end else if (d_store_done !== 1'b0) flag("d_store_done");

            if (i_fill_we !== 1'b0 || d_fill_we !== 1'b0) begin
                if (fillExp.size() == 0) flag("fill_we");
                else begin
                    fe = fillExp.pop_front();
                    chk("fill_cycle", 64'(cyc), 64'(fe.cyc));
                    chk("fill_write", {i_fill_we, d_fill_we, fill_word, fill_data, busy},
                        {fe.isI, !fe.isI, fe.word, fe.data, 1'b1});
                end
            end

            if ((i_tag_we | d_tag_we | i_fill_done | d_fill_done) !== 1'b0) begin
                if (doneExp.size() == 0) flag("fill_done");
                else begin
                    de = doneExp.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(de.cyc));
                    chk("done_flags", {i_tag_we, d_tag_we, i_fill_done, d_fill_done, busy},
                        {de.isI, !de.isI, de.isI, !de.isI, 1'b1});
                end
            end
        end
    end

    task automatic expectFill(input int unsigned n, input logic isI, input logic [15:0] base);
        logic [15:0] a;
        for (int unsigned k = 0; k < 8; k++) begin
            a = base | 16'(k << 1);
            memExp.push_back('{cyc: n + 1 + k, wr: 1'b0, addr: a, wdata: 16'h0, busy: 1'b1});
            fillExp.push_back('{cyc: n + 2 + LAT + k, isI: isI, word: 3'(k), data: memWord(a)});
        end
        doneExp.push_back('{cyc: n + 10 + LAT, isI: isI});
    endtask

    task automatic waitDone(input logic isI);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((isI ? i_fill_done : d_fill_done) === 1'b1) seen = 1'b1;
        end
        if (!seen) flag(isI ? "timeout_i_fill_done" : "timeout_d_fill_done");
        @(posedge clk); #1;
    endtask

    task automatic nextCycle();
        @(posedge clk); #1;
    endtask

    function automatic logic [60:0] allOuts();
        return {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we, d_fill_we,
                i_tag_we, d_tag_we, i_fill_done, d_fill_done, d_store_done, busy};
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        monEn = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 64'(allOuts()), 64'h0);
        nextCycle();

        // D miss at 0x1236
        d_miss = 1'b1; d_miss_addr = 16'h1236; n = cyc;
        expectFill(n, 1'b0, 16'h1230);
        waitDone(1'b0);
        d_miss = 1'b0;
        repeat (2) nextCycle();

        // simultaneous misses: D first, I accepted on IDLE re-entry
        d_miss = 1'b1; d_miss_addr = 16'h3458;
        i_miss = 1'b1; i_miss_addr = 16'h0204; n = cyc;
        expectFill(n, 1'b0, 16'h3450);
        expectFill(n + 11 + LAT, 1'b1, 16'h0200);
        waitDone(1'b0);
        d_miss = 1'b0;
        waitDone(1'b1);
        i_miss = 1'b0;
        repeat (2) nextCycle();

        // idle store
        d_store = 1'b1; d_store_addr = 16'h0040; d_store_data = 16'hBEEF;
        memExp.push_back('{cyc: cyc, wr: 1'b1, addr: 16'h0040, wdata: 16'hBEEF, busy: 1'b0});
        nextCycle();
        d_store = 1'b0;
        nextCycle();

        // store beats a simultaneous i_miss, which follows one cycle later
        d_store = 1'b1; d_store_addr = 16'h0F02; d_store_data = 16'h1357;
        i_miss = 1'b1; i_miss_addr = 16'h0ABC; n = cyc;
        memExp.push_back('{cyc: n, wr: 1'b1, addr: 16'h0F02, wdata: 16'h1357, busy: 1'b0});
        expectFill(n + 1, 1'b1, 16'h0AB0);
        nextCycle();
        d_store = 1'b0;
        waitDone(1'b1);
        i_miss = 1'b0;
        repeat (2) nextCycle();

        // I miss at top of address space, no wrap
        i_miss = 1'b1; i_miss_addr = 16'hFFFE; n = cyc;
        expectFill(n, 1'b1, 16'hFFF0);
        waitDone(1'b1);
        i_miss = 1'b0;
        repeat (2) nextCycle();

        // reset mid-fill with reads still outstanding
        d_miss = 1'b1; d_miss_addr = 16'h2222; n = cyc;
        for (int unsigned k = 0; k < 5; k++)
            memExp.push_back('{cyc: n + 1 + k, wr: 1'b0, addr: 16'h2220 | 16'(k << 1),
                               wdata: 16'h0, busy: 1'b1});
        repeat (5) nextCycle();
        rst_n = 1'b0; d_miss = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", 64'(allOuts()), 64'h0);
        repeat (6) nextCycle();
        chk("stale_resp_drained", 64'(respQ.size()), 64'h0);

        d_miss = 1'b1; d_miss_addr = 16'h4448; n = cyc;
        expectFill(n, 1'b0, 16'h4440);
        waitDone(1'b0);
        d_miss = 1'b0;
        repeat (10) nextCycle();

        chk("memExp_drained", 64'(memExp.size()), 64'h0);
        chk("fillExp_drained", 64'(fillExp.size()), 64'h0);
        chk("doneExp_drained", 64'(doneExp.size()), 64'h0);
        chk("idle_busy", 64'(busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
